// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
//
// Purpose:
//   Streaming 3x3 neighbourhood generator for a Sobel edge detector. Takes
//   one 8-bit grayscale pixel per accepted cycle in raster order. Two line
//   buffers hold the previous two rows. The block presents the full 3x3
//   window z0..z8 for every pixel position whose window lies entirely
//   inside the frame.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   pix_in     in   [7:0] input pixel
//   pix_valid  in   pix_in accepted this cycle (no backpressure)
//   sof        in   start of frame, qualified by pix_valid; pixel is (0,0)
//   z0..z8     out  [7:0] window: z0 z1 z2 top, z3 z4 z5 middle,
//                   z6 z7 z8 bottom (left to right), z4 = centre
//   win_valid  out  z0..z8 hold a complete in-frame window (1-cycle strobe)
//   win_last   out  with win_valid: last window of the frame
// ---------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] z0,
    output logic [7:0] z1,
    output logic [7:0] z2,
    output logic [7:0] z3,
    output logic [7:0] z4,
    output logic [7:0] z5,
    output logic [7:0] z6,
    output logic [7:0] z7,
    output logic [7:0] z8,
    output logic       win_valid,
    output logic       win_last
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Position of the next pixel to be accepted
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Position of the pixel on the input this cycle (sof overrides counters)
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2; not reset
    logic [7:0] r_lb0 [IMG_WIDTH];
    logic [7:0] r_lb1 [IMG_WIDTH];
    logic [7:0] w_a;
    logic [7:0] w_b;

    logic [7:0] r_z0, r_z1, r_z2, r_z3, r_z4, r_z5, r_z6, r_z7, r_z8;
    logic       r_vld_p0;
    logic       r_last_p0;

    always_comb begin
        w_col     = sof ? '0 : r_col;
        w_row     = sof ? '0 : r_row;
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end
    end

    // Combinational read returns the pre-write contents at this address
    assign w_a = r_lb0[w_col];
    assign w_b = r_lb1[w_col];

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb1[w_col] <= w_a;
            r_lb0[w_col] <= pix_in;
        end
    end

    // ---- stage p0: window shift register, validity, position counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_z0      <= '0;
            r_z1      <= '0;
            r_z2      <= '0;
            r_z3      <= '0;
            r_z4      <= '0;
            r_z5      <= '0;
            r_z6      <= '0;
            r_z7      <= '0;
            r_z8      <= '0;
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
        end else if (pix_valid) begin
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_z0      <= r_z1;
            r_z1      <= r_z2;
            r_z2      <= w_b;
            r_z3      <= r_z4;
            r_z4      <= r_z5;
            r_z5      <= w_a;
            r_z6      <= r_z7;
            r_z7      <= r_z8;
            r_z8      <= pix_in;
            // Rows 0..1 and cols 0..1 have no complete window; this also
            // masks stale line-buffer data after a new frame starts
            r_vld_p0  <= (w_row >= ROW_TWO) && (w_col >= COL_TWO);
            r_last_p0 <= (w_row == ROW_LAST) && (w_col == COL_LAST);
        end else begin
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
        end
    end

    assign z0        = r_z0;
    assign z1        = r_z1;
    assign z2        = r_z2;
    assign z3        = r_z3;
    assign z4        = r_z4;
    assign z5        = r_z5;
    assign z6        = r_z6;
    assign z7        = r_z7;
    assign z8        = r_z8;
    assign win_valid = r_vld_p0;
    assign win_last  = r_last_p0;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
    logic       win_valid;
    logic       win_last;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .z0        (z0),
        .z1        (z1),
        .z2        (z2),
        .z3        (z3),
        .z4        (z4),
        .z5        (z5),
        .z6        (z6),
        .z7        (z7),
        .z8        (z8),
        .win_valid (win_valid),
        .win_last  (win_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0][7:0] w_z;
    assign w_z = {z8, z7, z6, z5, z4, z3, z2, z1, z0};

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame image plus raster position of next pixel
    int img [H][W];
    int m_row = 0;
    int m_col = 0;
    bit m_hold = 0;
    int m_hold_win [9];
    int n_win = 0;
    int n_last = 0;
    bit tbl_on = 0;

    typedef struct {
        int row;
        int col;
        bit v;
        bit l;
        int z [9];
    } vec_t;
    localparam int NV = 7;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input int r, input int c, input bit v, input bit l,
                           input int a0, input int a1, input int a2, input int a3, input int a4,
                           input int a5, input int a6, input int a7, input int a8);
        tbl[k].row = r; tbl[k].col = c; tbl[k].v = v; tbl[k].l = l;
        tbl[k].z[0] = a0; tbl[k].z[1] = a1; tbl[k].z[2] = a2;
        tbl[k].z[3] = a3; tbl[k].z[4] = a4; tbl[k].z[5] = a5;
        tbl[k].z[6] = a6; tbl[k].z[7] = a7; tbl[k].z[8] = a8;
    endtask

    // Drive one cycle, advance the model, then check outputs 1 time unit
    // after the clock edge
    task automatic px(input bit v, input bit s, input int p);
        int r, c, idx;
        bit ev, el;
        int exp_w [9];
        r = 0; c = 0; ev = 0; el = 0;
        pix_valid = v;
        sof       = s;
        pix_in    = 8'(p);
        if (v) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = p;
            ev = (r >= 2) && (c >= 2);
            el = ev && (r == H - 1) && (c == W - 1);
            idx = (r * W + c + 1) % (W * H);
            m_row = idx / W;
            m_col = idx % W;
            if (ev)
                for (int i = 0; i < 9; i++) exp_w[i] = img[r - 2 + i / 3][c - 2 + i % 3];
        end
        @(posedge clk);
        #1;
        chk("win_valid", int'(win_valid), int'(ev));
        chk("win_last", int'(win_last), int'(el));
        if (ev) begin
            for (int i = 0; i < 9; i++) chk($sformatf("z%0d@(%0d,%0d)", i, r, c), int'(w_z[i]), exp_w[i]);
        end else if (!v && m_hold) begin
            for (int i = 0; i < 9; i++) chk($sformatf("hold_z%0d", i), int'(w_z[i]), m_hold_win[i]);
        end
        if (v) begin
            m_hold = ev;
            if (ev) for (int i = 0; i < 9; i++) m_hold_win[i] = exp_w[i];
        end
        if (win_valid) n_win++;
        if (win_last)  n_last++;
        if (v && tbl_on) begin
            for (int k = 0; k < NV; k++) begin
                if (tbl[k].row == r && tbl[k].col == c) begin
                    chk($sformatf("tbl%0d_valid", k), int'(win_valid), int'(tbl[k].v));
                    chk($sformatf("tbl%0d_last", k), int'(win_last), int'(tbl[k].l));
                    if (tbl[k].v)
                        for (int i = 0; i < 9; i++)
                            chk($sformatf("tbl%0d_z%0d", k, i), int'(w_z[i]), tbl[k].z[i]);
                end
            end
        end
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_win_valid"}, int'(win_valid), 0);
        chk({tag, "_win_last"}, int'(win_last), 0);
        for (int i = 0; i < 9; i++) chk($sformatf("%s_z%0d", tag, i), int'(w_z[i]), 0);
    endtask

    task automatic ramp_frame(input int off, input bit with_sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                px(1'b1, with_sof && r == 0 && c == 0, r * 16 + c + off);
    endtask

    initial begin
        set_vec(0, 2, 2, 1, 0,  0,  1,  2, 16, 17, 18, 32, 33, 34);
        set_vec(1, 1, 7, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        set_vec(2, 2, 1, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        set_vec(3, 3, 2, 1, 0, 16, 17, 18, 32, 33, 34, 48, 49, 50);
        set_vec(4, 2, 7, 1, 0,  5,  6,  7, 21, 22, 23, 37, 38, 39);
        set_vec(5, 4, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        set_vec(6, 5, 7, 1, 1, 53, 54, 55, 69, 70, 71, 85, 86, 87);

        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Ramp frame, continuous input, table-checked windows
        tbl_on = 1; n_win = 0; n_last = 0;
        ramp_frame(0, 1'b1);
        tbl_on = 0;
        chk("ramp_win_count", n_win, 24);
        chk("ramp_last_count", n_last, 1);

        // Same ramp with ~40% stall cycles
        n_win = 0; n_last = 0;
        begin
            int idx;
            idx = 0;
            while (idx < W * H) begin
                if ($urandom_range(0, 99) < 40) px(1'b0, 1'b0, 0);
                else begin
                    px(1'b1, idx == 0, (idx / W) * 16 + (idx % W));
                    idx++;
                end
            end
        end
        px(1'b0, 1'b0, 0);
        chk("stall_win_count", n_win, 24);
        chk("stall_last_count", n_last, 1);

        // Back-to-back frames, second offset +100, no idle at boundary
        n_win = 0; n_last = 0;
        ramp_frame(0, 1'b1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                px(1'b1, r == 0 && c == 0, r * 16 + c + 100);
                if (r == 2 && c == 2) begin
                    chk("f2_first_z0", int'(z0), 100);
                    chk("f2_first_z8", int'(z8), 134);
                end
            end
        chk("b2b_win_count", n_win, 48);
        chk("b2b_last_count", n_last, 2);

        // Mid-frame sof at (3,4), then a full ramp frame
        for (int i = 0; i < 3 * W + 4; i++) px(1'b1, i == 0, 200 - i);
        n_win = 0; n_last = 0;
        ramp_frame(0, 1'b1);
        chk("midsof_win_count", n_win, 24);
        chk("midsof_last_count", n_last, 1);

        // Asynchronous reset mid-frame, right after a valid window
        for (int i = 0; i <= 3 * W + 4; i++) px(1'b1, i == 0, i + 7);
        chk("pre_reset_valid", int'(win_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_row = 0; m_col = 0; m_hold = 0;
        n_win = 0; n_last = 0;
        ramp_frame(50, 1'b0);
        chk("post_rst_win_count", n_win, 24);
        chk("post_rst_last_count", n_last, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 neighbourhood generator that feeds the Sobel edge detector. It accepts one 8-bit grayscale pixel per cycle in raster order. Two internal line buffers hold the previous two rows. It presents the full 3x3 window z0..z8, with a valid strobe, for every pixel position whose window lies fully inside the frame.

## Interface
- IMG_WIDTH, 640, pixels per line (>= 3); line buffer depth
- IMG_HEIGHT, 480, lines per frame (>= 3)
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous, active-low reset
- pix_in  in  8  input pixel
- pix_valid  in  1  pix_in is accepted this cycle; no backpressure
- sof  in  1  start of frame, qualified by pix_valid; the pixel carrying it is (row 0, col 0)
- z0..z8  out  8 each  window: z0 z1 z2 = top row (left to right), z3 z4 z5 = middle, z6 z7 z8 = bottom; z4 = centre
- win_valid  out  1  z0..z8 hold a complete in-frame window (one-cycle strobe)
- win_last  out  1  with win_valid: this is the last window of the frame

## Operation
- Counters: col in 0..IMG_WIDTH-1 and row in 0..IMG_HEIGHT-1 give the position of the next accepted pixel.
  - Each accepted pixel advances col.
  - At col = IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0.
- sof with pix_valid forces the current pixel to position (0,0), whatever the counter state. Counters then continue from (0,1).
  - A mid-frame sof abandons the old frame.
  - No window is emitted until row 2 of the new frame.
- Line buffers lb0 (row r-1) and lb1 (row r-2) are IMG_WIDTH entries each, addressed by col. On an accepted pixel at col c:
  - read a = lb0[c] and b = lb1[c];
  - write lb1[c] <= a and lb0[c] <= pix_in.
- Window shift on an accepted pixel:
  - z0<=z1, z1<=z2, z3<=z4, z4<=z5, z6<=z7, z7<=z8;
  - z2<=b, z5<=a, z8<=pix_in.
- Window validity: the accepted pixel at (r,c) completes the window centred at (r-1,c-1). win_valid is registered high the next cycle iff r>=2 and c>=2.
- Window count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame. Border pixels get no window and no padding.
- win_last is registered high alongside win_valid iff r = IMG_HEIGHT-1 and c = IMG_WIDTH-1.
- Stall cycles (pix_valid=0): counters, line buffers and z0..z8 hold. win_valid and win_last are 0.
- Line-buffer contents are not reset. Stale data from a prior frame is never flagged valid, because valid requires r>=2.

## Timing
- Latency: one clk from accepting the bottom-right pixel of a window to win_valid with that window on z0..z8.
- Throughput: one window per cycle during in-frame runs (sustained pix_valid).
- z0..z8 are registered and keep their value until the next accepted pixel.
- Reset (rst_n low, asynchronous): z0..z8 = 0, win_valid = 0, win_last = 0, col = 0, row = 0.
  - First accepted pixel after release is (0,0), whether or not sof is asserted.
  - A reset mid-frame discards that frame.
- Frame wrap: a pixel at (0,0) arriving on the cycle right after the last pixel needs no idle cycle. The window from the last pixel still reports win_valid=1 and win_last=1.
- Line-buffer read-before-write at the same address in the same cycle must return the old value. Registered-output RAM is allowed only if the external behaviour above is unchanged.

## Test plan
- Ramp frame, IMG_WIDTH=8, IMG_HEIGHT=6, pix = row*16+col, pix_valid always 1:
  - cycle after pixel (2,2): win_valid=1 with z0..z8 = 0,1,2,16,17,18,32,33,34;
  - exactly 24 win_valid pulses per frame;
  - win_last only on the window with z8=87.
- Same ramp with pix_valid deasserted randomly about 40% of cycles: identical sequence of windows. win_valid is never high on a cycle after a stall.
- Two back-to-back frames, second ramp offset +100, sof on each first pixel: frame 2's first window is z0=100 … z8=134. No window contains frame-1 data, and there is no gap at the boundary.
- Mid-frame sof at (3,4) of frame 1, then a full ramp frame: no win_valid until new pixel (2,2). Count is 24 from that sof.
- rst_n pulsed low asynchronously mid-frame (between clk edges): outputs 0 immediately. After release, the next pixel is treated as (0,0) even without sof, and the first window comes at (2,2).
- Column boundary, IMG_WIDTH=8: pixels at col 0 and 1 of rows >=2 produce win_valid=0. The window at col 2 contains no pixel values from the previous row's columns 6..7.
